// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin sharing of the L2 port between the I-cache and D-cache with saturating grant counters
module l2_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_read,
    input  logic              ic_write,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic [DATA_W-1:0] ic_wdata,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_ready,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_ready,
    output logic              L2_read,
    output logic              L2_write,
    output logic [ADDR_W-1:0] L2_addr,
    output logic [DATA_W-1:0] L2_wdata,
    input  logic [DATA_W-1:0] L2_rdata,
    input  logic              L2_ready,
    output logic [CNT_W-1:0]  ic_grant_cnt,
    output logic [CNT_W-1:0]  dc_grant_cnt
);
    typedef enum logic [1:0] {IDLE, BUSY_IC, BUSY_DC} state_t;
    state_t state, state_next;
    logic last_dc, ic_pend, dc_pend, grant_ic, grant_dc, done;

    always_comb begin
        ic_pend    = ic_read | ic_write;
        dc_pend    = dc_read | dc_write;
        done       = (state != IDLE) && L2_ready;
        // A completing requester can only hand the port to the other side, never back to itself
        grant_ic   = (state == IDLE) ? ic_pend && (!dc_pend || last_dc)
                                     : (state == BUSY_DC) && L2_ready && ic_pend;
        grant_dc   = (state == IDLE) ? dc_pend && (!ic_pend || !last_dc)
                                     : (state == BUSY_IC) && L2_ready && dc_pend;
        state_next = grant_ic ? BUSY_IC : grant_dc ? BUSY_DC : done ? IDLE : state;
    end

    assign ic_ready = (state == BUSY_IC) && L2_ready;
    assign dc_ready = (state == BUSY_DC) && L2_ready;
    assign ic_rdata = (state == BUSY_IC) ? L2_rdata : '0;
    assign dc_rdata = (state == BUSY_DC) ? L2_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_dc      <= 1'b1;
            L2_read      <= 1'b0;
            L2_write     <= 1'b0;
            L2_addr      <= '0;
            L2_wdata     <= '0;
            ic_grant_cnt <= '0;
            dc_grant_cnt <= '0;
        end else begin
            state <= state_next;
            if (grant_ic) begin
                L2_read      <= ic_read & ~ic_write;
                L2_write     <= ic_write;
                L2_addr      <= ic_addr;
                L2_wdata     <= ic_wdata;
                last_dc      <= 1'b0;
                ic_grant_cnt <= ic_grant_cnt + CNT_W'(~&ic_grant_cnt);
            end else if (grant_dc) begin
                L2_read      <= dc_read & ~dc_write;
                L2_write     <= dc_write;
                L2_addr      <= dc_addr;
                L2_wdata     <= dc_wdata;
                last_dc      <= 1'b1;
                dc_grant_cnt <= dc_grant_cnt + CNT_W'(~&dc_grant_cnt);
            end else if (done) begin
                L2_read  <= 1'b0;
                L2_write <= 1'b0;
            end
        end
    end
endmodule
